alu_z_stage: RTL

Result-capture stage placed directly downstream of the datapath's combinational ALU units (rotate, shift, logic, mul/div). On a capture request it waits a programmable settle interval, then latches the 32- or 64-bit result into the ZHi/ZLo pair, derives zero/negative flags and serves both halves onto the internal bus under Zhighout/Zlowout control. Multi-cycle sequencing, back-to-back capture and request-collision detection are the block's responsibility, not the control unit's.

---
 rtl/alu_z_pkg.sv | 13 +
 rtl/alu_z_readmux.sv | 29 ++
 rtl/alu_z_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_z_pkg.sv
// Shared types and constants for the Z result-capture stage.
package alu_z_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } z_state_e;

  localparam int SETTLE_W   = 3;
  localparam int SETTLE_MAX = 7;

endpackage

// File: rtl/alu_z_readmux.sv
// Bus read select for the ZHi/ZLo pair; a double select drives nothing and flags an error.
module alu_z_readmux
  import alu_z_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] ZHi,
  input  logic [WIDTH-1:0] ZLo,
  input  logic             Zhighout,
  input  logic             Zlowout,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_drive,
  output logic             sel_err
);

  always_comb begin
    bus_out   = '0;
    bus_drive = 1'b0;
    sel_err   = Zhighout & Zlowout;
    if (Zhighout && !Zlowout) begin
      bus_out   = ZHi;
      bus_drive = 1'b1;
    end else if (Zlowout && !Zhighout) begin
      bus_out   = ZLo;
      bus_drive = 1'b1;
    end
  end

endmodule

// File: rtl/alu_z_stage.sv
// Z result-capture stage: waits SETTLE cycles after a request, latches the ALU result
// into ZHi/ZLo with zero/neg flags, and serves either half onto the internal bus.
module alu_z_stage
  import alu_z_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             Zin,
  input  logic             wide,
  input  logic [WIDTH-1:0] res_lo,
  input  logic [WIDTH-1:0] res_hi,
  input  logic             Zhighout,
  input  logic             Zlowout,
  output logic [WIDTH-1:0] ZHi,
  output logic [WIDTH-1:0] ZLo,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_drive,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             neg,
  output logic             overrun,
  output logic             sel_err
);

  // Out-of-range settle values saturate to the counter's reach.
  localparam logic [SETTLE_W-1:0] SETTLE_LD =
    (SETTLE > SETTLE_MAX) ? SETTLE_W'(SETTLE_MAX) : SETTLE_W'(SETTLE);

  z_state_e            state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic                wide_q, wide_d;
  logic                ovr_q, ovr_d;
  logic [WIDTH-1:0]    zhi_q, zhi_d;
  logic [WIDTH-1:0]    zlo_q, zlo_d;
  logic                zero_q, zero_d;
  logic                neg_q, neg_d;
  logic                capture;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wide_q  <= 1'b0;
      ovr_q   <= 1'b0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wide_q  <= wide_d;
      ovr_q   <= ovr_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  // DONE accepts a new request exactly like IDLE, giving back-to-back captures.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wide_d  = wide_q;
    ovr_d   = ovr_q;
    capture = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (Zin) begin
          state_d = WAIT;
          cnt_d   = SETTLE_LD;
          wide_d  = wide;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (Zin) ovr_d = 1'b1;
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    zhi_d  = zhi_q;
    zlo_d  = zlo_q;
    zero_d = zero_q;
    neg_d  = neg_q;
    if (capture) begin
      zlo_d  = res_lo;
      zhi_d  = wide_q ? res_hi : '0;
      zero_d = (res_lo == '0) && (!wide_q || (res_hi == '0));
      neg_d  = wide_q ? res_hi[WIDTH-1] : res_lo[WIDTH-1];
    end
  end

  always_comb begin
    busy = (state_q == WAIT);
    done = (state_q == DONE);
  end

  assign ZHi     = zhi_q;
  assign ZLo     = zlo_q;
  assign zero    = zero_q;
  assign neg     = neg_q;
  assign overrun = ovr_q;

  alu_z_readmux #(
    .WIDTH (WIDTH)
  ) u_readmux (
    .ZHi       (zhi_q),
    .ZLo       (zlo_q),
    .Zhighout  (Zhighout),
    .Zlowout   (Zlowout),
    .bus_out   (bus_out),
    .bus_drive (bus_drive),
    .sel_err   (sel_err)
  );

endmodule
